// File: rtl/ssb_demod.sv
// Coherent quadrature downconverter: mixes a real sample stream with an NCO
// cos/sin pair and integrate-and-dumps the products into decimated I/Q words.
module ssb_demod #(
    parameter int DEC_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        phase_inc,
    input  logic               phase_load,
    input  logic signed [15:0] s_in,
    input  logic               s_valid,
    output logic signed [31:0] i_out,
    output logic signed [31:0] q_out,
    output logic               out_valid
);

    localparam int AW = 32 + DEC_LOG2;
    localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;

    // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64.
    localparam logic signed [15:0] QTR [0:64] = '{
        16'sd0,     16'sd804,   16'sd1608,  16'sd2410,  16'sd3212,  16'sd4011,  16'sd4808,  16'sd5602,
        16'sd6393,  16'sd7179,  16'sd7962,  16'sd8739,  16'sd9512,  16'sd10278, 16'sd11039, 16'sd11793,
        16'sd12539, 16'sd13279, 16'sd14010, 16'sd14732, 16'sd15446, 16'sd16151, 16'sd16846, 16'sd17530,
        16'sd18204, 16'sd18868, 16'sd19519, 16'sd20159, 16'sd20787, 16'sd21403, 16'sd22005, 16'sd22594,
        16'sd23170, 16'sd23731, 16'sd24279, 16'sd24811, 16'sd25329, 16'sd25832, 16'sd26319, 16'sd26790,
        16'sd27245, 16'sd27683, 16'sd28105, 16'sd28510, 16'sd28898, 16'sd29268, 16'sd29621, 16'sd29956,
        16'sd30273, 16'sd30571, 16'sd30852, 16'sd31113, 16'sd31356, 16'sd31580, 16'sd31785, 16'sd31971,
        16'sd32137, 16'sd32285, 16'sd32412, 16'sd32521, 16'sd32609, 16'sd32678, 16'sd32728, 16'sd32757,
        16'sd32767
    };

    logic [31:0]          phase_inc_r;
    logic [31:0]          phase_acc;
    logic signed [15:0]   s_r;
    logic signed [15:0]   cos_r;
    logic signed [15:0]   sin_r;
    logic signed [15:0]   cos_lu;
    logic signed [15:0]   sin_lu;
    logic signed [31:0]   p_i;
    logic signed [31:0]   p_q;
    logic                 v1;
    logic                 v2;
    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] sum_i;
    logic signed [AW-1:0] sum_q;
    logic [DEC_LOG2-1:0]  count;

    // Full 256-entry sine folded out of the quarter table; cos is sin shifted a quarter turn.
    function automatic logic signed [15:0] sin_of(input logic [7:0] k);
        logic [6:0]         idx;
        logic signed [15:0] mag;
        idx = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
        mag = QTR[idx];
        return k[7] ? -mag : mag;
    endfunction

    always_comb begin
        sin_lu = sin_of(phase_acc[31:24]);
        cos_lu = sin_of(phase_acc[31:24] + 8'd64);
        sum_i  = acc_i + AW'(p_i);
        sum_q  = acc_q + AW'(p_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_inc_r <= '0;
            phase_acc   <= '0;
            s_r         <= '0;
            cos_r       <= '0;
            sin_r       <= '0;
            p_i         <= '0;
            p_q         <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            acc_i       <= '0;
            acc_q       <= '0;
            count       <= '0;
            i_out       <= '0;
            q_out       <= '0;
            out_valid   <= 1'b0;
        end else if (phase_load) begin
            phase_inc_r <= phase_inc;
            phase_acc   <= '0;
            acc_i       <= '0;
            acc_q       <= '0;
            count       <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            v1 <= s_valid;
            if (s_valid) begin
                s_r       <= s_in;
                cos_r     <= cos_lu;
                sin_r     <= sin_lu;
                phase_acc <= phase_acc + phase_inc_r;
            end

            v2 <= v1;
            if (v1) begin
                p_i <= s_r * cos_r;
                p_q <= s_r * sin_r;
            end

            // Last sample of the block is folded straight into the dump.
            if (v2) begin
                if (count != CNT_LAST) begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    count <= count + 1'b1;
                end else begin
                    i_out     <= 32'(sum_i >>> DEC_LOG2);
                    q_out     <= 32'(sum_q >>> DEC_LOG2);
                    out_valid <= 1'b1;
                    acc_i     <= '0;
                    acc_q     <= '0;
                    count     <= '0;
                end
            end
        end
    end

endmodule
